unified_mem_arb: RTL
====================

Name: unified_mem_arb

Overview:
- Shares one single-port RAM (async read, sync write, word-addressed) between the pipeline's instruction-fetch port and its data (MEM-stage) port.
- Sits between the CPU core and the RAM instance, replacing the split instruction/data RAM pair.
- Data port has priority. A starvation counter guarantees fetch progress.
- Read data is registered and returned one cycle after grant.

Parameters:
- ADDR_W, 32, byte-address width of the requester ports.
- DATA_W, 32, data width.
- RAM_AW, 10, RAM word-address width; ram_a = addr[RAM_AW+1:2].
- STARVE_MAX, 4, number of consecutive denied fetch-request cycles after which fetch wins; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  if_rdata valid (registered, 1 cycle after if_gnt).
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid (reads only, 1 cycle after d_gnt).
- d_rdata  out  DATA_W  load data.
- ram_we  out  1  RAM write enable.
- ram_a  out  RAM_AW  RAM word address.
- ram_d  out  DATA_W  RAM write data.
- ram_spo  in  DATA_W  RAM async read data.

Behaviour:
- Reset (async, rst=1):
  - starve_cnt=0, both rvalid=0, both rdata=0.
  - if_gnt=d_gnt=0 and ram_we=0 while rst=1.
  - Any rvalid pending from the pre-reset cycle is dropped.
- Arbitration, combinational each cycle:
  - starve = (starve_cnt == STARVE_MAX).
  - d_gnt = d_req & ~(if_req & starve).
  - if_gnt = if_req & ~d_gnt.
  - At most one grant per cycle.
- RAM drive:
  - ram_a = granted port's addr[RAM_AW+1:2]; if_addr when idle.
  - ram_we = d_gnt & d_we.
  - ram_d = d_wdata always.
  - Write commits at the clk edge ending the grant cycle.
- Read return:
  - At the edge ending a read-grant cycle, ram_spo is latched into the granted port's rdata and that port's rvalid=1 for exactly one cycle.
  - The other port's rdata holds its previous value.
  - Writes produce no d_rvalid.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each cycle with if_req=1 and if_gnt=0.
  - Clears on if_gnt=1 or if_req=0.
- Throughput:
  - Back-to-back grants are allowed every cycle.
  - A sole requester is granted every cycle with zero wait.
- Address bits [1:0] are ignored. Bits above RAM_AW+1 are ignored, so accesses wrap modulo RAM size.
- Simultaneous events:
  - Reads and writes never overlap (single grant).
  - A data read granted the cycle after a write to the same word returns the new value.

Optional Feature:
Macro DBG_PORT_EN.
- Defined: adds ports dbg_req (in 1), dbg_addr (in ADDR_W), dbg_gnt (out 1), dbg_rvalid (out 1), dbg_rdata (out DATA_W).
  - Debug is read-only and lowest priority: dbg_gnt = dbg_req & ~if_req & ~d_req.
  - Debug reads return with the same 1-cycle latency as the other ports.
  - Debug reads never affect starve_cnt.
- Undefined: debug ports and logic are absent; behaviour is exactly as above.

Test Plan:
- Fetch only: if_req=1 with if_addr=0x0,0x4,0x8 on consecutive cycles → if_gnt=1 every cycle; if_rvalid=1 one cycle later with RAM words 0,1,2.
- Write then read: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF; next cycle d_we=0 with the same address → d_rvalid=1 the following cycle with d_rdata=0xDEADBEEF; d_rvalid=0 after the write.
- Contention: if_req=1 and d_req=1 held continuously, STARVE_MAX=4 → d_gnt for 4 cycles, if_gnt on the 5th, then the pattern repeats (4 data : 1 fetch).
- Wrap: RAM_AW=10, write 0x55 to d_addr=0x1000 → read at d_addr=0x0000 returns 0x55.
- Reset mid-operation: assert rst in the cycle after a read grant → if_rvalid and d_rvalid stay 0, starve_cnt=0; first grant after release behaves as from reset.
- DBG_PORT_EN defined: dbg_req with if_req=1 → dbg_gnt=0; once all other requests drop → dbg_gnt=1, and dbg_rvalid with the correct word follows one cycle later.

Source files
------------

// File: rtl/unified_mem_arb_if.sv
// Bus bundle for unified_mem_arb: fetch port, data port, RAM side and,
// when DBG_PORT_EN is defined, a read-only debug port.
// slave  = arbiter view, master = core/RAM view.
interface unified_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RAM_AW = 10
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              ram_we;
    logic [RAM_AW-1:0] ram_a;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_spo;

`ifdef DBG_PORT_EN
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
`endif

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
`ifdef DBG_PORT_EN
        input  dbg_req, dbg_addr,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
`endif
        output ram_we, ram_a, ram_d,
        input  ram_spo
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
`ifdef DBG_PORT_EN
        output dbg_req, dbg_addr,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
`endif
        input  ram_we, ram_a, ram_d,
        output ram_spo
    );
endinterface

// File: rtl/unified_mem_arb.sv
// unified_mem_arb: shares one single-port RAM (async read, sync write)
// between instruction fetch and the data port. Data has priority; a
// starvation counter forces a fetch grant after STARVE_MAX denied cycles.
// Read data is registered and returned one cycle after the grant.
// Optional read-only, lowest-priority debug port: define DBG_PORT_EN.
module unified_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_AW     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    unified_mem_arb_if.slave   bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       starve;
    logic       if_gnt_c;
    logic       d_gnt_c;
    logic       d_rd_gnt;
    logic       unused_addr_bits;

`ifdef DBG_PORT_EN
    logic       dbg_gnt_c;
`endif

    // Grant decision: data first unless fetch has been starved long enough
    always_comb begin
        starve   = (starve_cnt == STARVE_LIM);
        d_gnt_c  = ~rst & bus.d_req & ~(bus.if_req & starve);
        if_gnt_c = ~rst & bus.if_req & ~d_gnt_c;
        d_rd_gnt = d_gnt_c & ~bus.d_we;
`ifdef DBG_PORT_EN
        dbg_gnt_c = ~rst & bus.dbg_req & ~bus.if_req & ~bus.d_req;
`endif
    end

    // RAM drive: address follows the granted port, fetch address when idle
    always_comb begin
        bus.ram_a = bus.if_addr[RAM_AW+1:2];
        if (d_gnt_c) begin
            bus.ram_a = bus.d_addr[RAM_AW+1:2];
        end
`ifdef DBG_PORT_EN
        else if (dbg_gnt_c) begin
            bus.ram_a = bus.dbg_addr[RAM_AW+1:2];
        end
`endif
        bus.ram_we = d_gnt_c & bus.d_we;
        bus.ram_d  = bus.d_wdata;
        bus.if_gnt = if_gnt_c;
        bus.d_gnt  = d_gnt_c;
`ifdef DBG_PORT_EN
        bus.dbg_gnt = dbg_gnt_c;
`endif
    end

    // Byte-lane bits and bits above the RAM size take no part in addressing
    always_comb begin
        unused_addr_bits = ^{bus.if_addr[ADDR_W-1:RAM_AW+2], bus.if_addr[1:0],
                             bus.d_addr[ADDR_W-1:RAM_AW+2], bus.d_addr[1:0]
`ifdef DBG_PORT_EN
                             , bus.dbg_addr[ADDR_W-1:RAM_AW+2], bus.dbg_addr[1:0]
`endif
                            };
    end

    // Starvation counter: counts denied fetch cycles, saturates at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (bus.if_req & ~if_gnt_c) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Fetch read return, one cycle after grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
        end else begin
            bus.if_rvalid <= if_gnt_c;
            if (if_gnt_c) begin
                bus.if_rdata <= bus.ram_spo;
            end
        end
    end

    // Data read return; writes produce no rvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.d_rvalid <= 1'b0;
            bus.d_rdata  <= '0;
        end else begin
            bus.d_rvalid <= d_rd_gnt;
            if (d_rd_gnt) begin
                bus.d_rdata <= bus.ram_spo;
            end
        end
    end

`ifdef DBG_PORT_EN
    // Debug read return, same latency as the other ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dbg_rvalid <= 1'b0;
            bus.dbg_rdata  <= '0;
        end else begin
            bus.dbg_rvalid <= dbg_gnt_c;
            if (dbg_gnt_c) begin
                bus.dbg_rdata <= bus.ram_spo;
            end
        end
    end
`endif
endmodule
